// File: rtl/wired_resolve_bank.sv
// wired_resolve_bank: resolves NCH tri-state style drivers into one value
// (wand / wor / parity / priority), with trireg retention when nobody
// drives, then width-adapts the result. Two-stage valid/ready pipeline.
// Optional feature macro: WRB_CONFLICT_CNT_EN (saturating count of
// conflicting output beats on conflict_cnt; constant 0 when undefined).
module wired_resolve_bank #(
  parameter int NCH   = 4,
  parameter int IN_W  = 8,
  parameter int OUT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NCH*IN_W-1:0] drv,
  input  logic [NCH-1:0]      drv_en,
  input  logic [1:0]          mode,
  input  logic                ext_sign,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_undriven,
  output logic                out_conflict,
  output logic [15:0]         conflict_cnt
);

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_PRIO = 2'b11
  } mode_e;

  logic [IN_W-1:0]  and_v, or_v, xor_v, prio_v, ch, res;
  logic             found, undriven, conflict;
  logic             s1_valid, s1_und, s1_conf, s1_load, s1_adv, s2_ready;
  logic [IN_W-1:0]  s1_val;
  logic [OUT_W-1:0] adapted;

  // Handshake: each stage takes a beat when empty or draining this cycle.
  assign s2_ready = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_ready;
  assign in_ready = !s1_valid || s1_adv;
  assign s1_load  = in_valid && in_ready;

  // Resolve all enabled channels in every mode; AND != OR over the enabled
  // set means at least one bit differs between two drivers.
  always_comb begin
    and_v  = '1;
    or_v   = '0;
    xor_v  = '0;
    prio_v = '0;
    ch     = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (drv_en[i]) begin
        ch    = drv[i*IN_W +: IN_W];
        and_v = and_v & ch;
        or_v  = or_v | ch;
        xor_v = xor_v ^ ch;
        if (!found) begin
          prio_v = ch;
          found  = 1'b1;
        end
      end
    end
    undriven = ~|drv_en;
    unique case (mode_e'(mode))
      MODE_AND:  res = and_v;
      MODE_OR:   res = or_v;
      MODE_XOR:  res = xor_v;
      MODE_PRIO: res = prio_v;
    endcase
    conflict = !undriven && (mode_e'(mode) != MODE_XOR) && (and_v != or_v);
  end

  // Stage 1: resolved value; an undriven beat leaves s1_val untouched, which
  // is exactly the last driven value (trireg retention).
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_val   <= '0;
      s1_und   <= 1'b0;
      s1_conf  <= 1'b0;
    end else begin
      s1_valid <= s1_load || (s1_valid && !s1_adv);
      if (s1_load) begin
        if (!undriven) s1_val <= res;
        s1_und  <= undriven;
        s1_conf <= conflict;
      end
    end
  end

  // Width adaptation of the stage-1 value.
  if (OUT_W > IN_W) begin : g_ext
    logic s1_ext;
    // Extension mode travels with its beat.
    always_ff @(posedge clk) begin
      if (rst)          s1_ext <= 1'b0;
      else if (s1_load) s1_ext <= ext_sign;
    end
    assign adapted = {{(OUT_W-IN_W){s1_ext & s1_val[IN_W-1]}}, s1_val};
  end else if (OUT_W == IN_W) begin : g_pass
    logic unused_ext;
    assign unused_ext = ext_sign;
    assign adapted    = s1_val;
  end else begin : g_trunc
    logic unused_bits;
    assign unused_bits = ^{ext_sign, s1_val[IN_W-1:OUT_W]};
    assign adapted     = s1_val[OUT_W-1:0];
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_undriven <= 1'b0;
      out_conflict <= 1'b0;
    end else begin
      out_valid <= s1_adv || (out_valid && !out_ready);
      if (s1_adv) begin
        out_data     <= adapted;
        out_undriven <= s1_und;
        out_conflict <= s1_conf;
      end
    end
  end

`ifdef WRB_CONFLICT_CNT_EN
  // Saturating count of transferred beats flagged as conflicting.
  always_ff @(posedge clk) begin
    if (rst)
      conflict_cnt <= '0;
    else if (out_valid && out_ready && out_conflict && (conflict_cnt != 16'hFFFF))
      conflict_cnt <= conflict_cnt + 16'd1;
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule
